fifo_flags: RTL and testbench

- Single synchronous FIFO that generates the four occupancy status flags consumed by the flow-control stage.
- The flags are full, almost_full, empty and almost_empty.
- One instance per queue; five instances feed the flow-control stage's ff/aff/ef/aef inputs.
- The read side is gated by that queue's continuar bit (enable), so a paused consumer stops draining while the producer may keep filling.

---
 rtl/fifo_flags_if.sv | 34 +++
 rtl/fifo_flags.sv | 92 +++++++++
 tb/tb_fifo_flags.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_flags_if.sv
// Queue-side bundle of a fifo_flags instance: producer/consumer
// requests plus the occupancy flags sent to flow control.
interface fifo_flags_if #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
);
  logic                  enable;
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic [ADDR_WIDTH:0]   count;
  logic                  full;
  logic                  almost_full;
  logic                  empty;
  logic                  almost_empty;
  logic                  overflow_err;
  logic                  underflow_err;

  modport master (
    output enable, push, data_in, pop,
    input  data_out, valid_out, count,
    input  full, almost_full, empty, almost_empty,
    input  overflow_err, underflow_err
  );

  modport slave (
    input  enable, push, data_in, pop,
    output data_out, valid_out, count,
    output full, almost_full, empty, almost_empty,
    output overflow_err, underflow_err
  );
endinterface

// File: rtl/fifo_flags.sv
// Synchronous FIFO with registered read data and occupancy flags
// for one flow-controlled queue; reads are paused by enable.
module fifo_flags #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 2
) (
  input logic         clk,
  input logic         reset,
  fifo_flags_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  localparam logic [CW-1:0] AF_N   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_N   = CW'(AE_THRESH);

  if (!(AE_THRESH > 0 && AE_THRESH < AF_THRESH &&
        AF_THRESH < DEPTH)) begin : g_bad_thresh
    $error("fifo_flags: need 0 < AE_THRESH < AF_THRESH < DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;
  logic                  ovf_q;
  logic                  udf_q;

  logic full_w;
  logic empty_w;
  logic pop_ok;
  logic push_ok;

  assign full_w  = (count_q == FULL_N);
  assign empty_w = (count_q == '0);
  assign pop_ok  = bus.pop & bus.enable & ~empty_w;
  assign push_ok = bus.push & (~full_w | pop_ok);

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      valid_q <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout_q <= mem[rd_ptr];
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (bus.push && full_w && !pop_ok) begin
        ovf_q <= 1'b1;
      end
      if (bus.pop && bus.enable && empty_w) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign bus.data_out      = dout_q;
  assign bus.valid_out     = valid_q;
  assign bus.count         = count_q;
  assign bus.full          = full_w;
  assign bus.almost_full   = (count_q >= AF_N);
  assign bus.empty         = empty_w;
  assign bus.almost_empty  = (count_q <= AE_N);
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;
endmodule

// File: tb/tb_fifo_flags.sv
// Directed self-checking bench for fifo_flags.
// Inputs change 1ns after posedge; outputs are sampled there too.
module tb_fifo_flags;
  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  fifo_flags_if #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) bus ();

  fifo_flags #(
    .DATA_WIDTH(6),
    .ADDR_WIDTH(3),
    .AF_THRESH (6),
    .AE_THRESH (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bus.enable = 1'b1;
    bus.push = 1'b0;
    bus.pop = 1'b0;
    bus.data_in = '0;
    do_reset();
    n_total++;
    if (bus.count !== 4'd0)
      $display("FAIL reset_count got %0d want 0", bus.count);
    else n_pass++;
    n_total++;
    if ({bus.empty, bus.almost_empty, bus.full, bus.almost_full}
        !== 4'b1100)
      $display("FAIL reset_flags got %b want 1100",
        {bus.empty, bus.almost_empty, bus.full, bus.almost_full});
    else n_pass++;
    n_total++;
    if ({bus.valid_out, bus.data_out} !== 7'd0)
      $display("FAIL reset_dout got %b/%h want 0/00",
        bus.valid_out, bus.data_out);
    else n_pass++;
    n_total++;
    if ({bus.overflow_err, bus.underflow_err} !== 2'b00)
      $display("FAIL reset_err got %b%b want 00",
        bus.overflow_err, bus.underflow_err);
    else n_pass++;
  endtask

  task automatic test_fill();
    // count, af, full, ae after each of 8 pushes
    logic [6:0] exp_t [8];
    exp_t = '{ {4'd1, 3'b001}, {4'd2, 3'b001}, {4'd3, 3'b000},
               {4'd4, 3'b000}, {4'd5, 3'b000}, {4'd6, 3'b100},
               {4'd7, 3'b100}, {4'd8, 3'b110} };
    for (int i = 0; i < 8; i++) begin
      bus.push = 1'b1;
      bus.data_in = 6'(i + 1);
      step();
      n_total++;
      if ({bus.count, bus.almost_full, bus.full, bus.almost_empty}
          !== exp_t[i])
        $display("FAIL fill_%0d got %0d/%b%b%b want %0d/%b", i + 1,
          bus.count, bus.almost_full, bus.full, bus.almost_empty,
          exp_t[i][6:3], exp_t[i][2:0]);
      else n_pass++;
    end
    bus.push = 1'b0;
  endtask

  task automatic test_overflow();
    bus.push = 1'b1;
    bus.data_in = 6'h3F;
    step();
    bus.push = 1'b0;
    n_total++;
    if ({bus.overflow_err, bus.count} !== {1'b1, 4'd8})
      $display("FAIL ovf got err=%b cnt=%0d want 1/8",
        bus.overflow_err, bus.count);
    else n_pass++;
    bus.pop = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      n_total++;
      if ({bus.valid_out, bus.data_out} !== {1'b1, 6'(i)})
        $display("FAIL ovf_drain_%0d got %b/%h want 1/%h", i,
          bus.valid_out, bus.data_out, i);
      else n_pass++;
    end
    bus.pop = 1'b0;
    step();
    n_total++;
    if ({bus.valid_out, bus.count, bus.empty, bus.overflow_err}
        !== {1'b0, 4'd0, 1'b1, 1'b1})
      $display("FAIL ovf_after got v=%b c=%0d e=%b o=%b want 0/0/1/1",
        bus.valid_out, bus.count, bus.empty, bus.overflow_err);
    else n_pass++;
  endtask

  task automatic test_pause();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.push = 1'b1;
      bus.data_in = 6'h11 + 6'(i);
      step();
    end
    bus.push = 1'b0;
    bus.pop = 1'b1;
    bus.enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_total++;
      if ({bus.valid_out, bus.count, bus.underflow_err}
          !== {1'b0, 4'd4, 1'b0})
        $display("FAIL pause_%0d got v=%b c=%0d u=%b want 0/4/0", i,
          bus.valid_out, bus.count, bus.underflow_err);
      else n_pass++;
    end
    bus.enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_total++;
      if ({bus.valid_out, bus.data_out} !== {1'b1, 6'h11 + 6'(i)})
        $display("FAIL resume_%0d got %b/%h want 1/%h", i,
          bus.valid_out, bus.data_out, 6'h11 + 6'(i));
      else n_pass++;
    end
    bus.pop = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.push = 1'b1;
      bus.data_in = 6'h21 + 6'(i);
      step();
    end
    bus.data_in = 6'h2A;
    bus.pop = 1'b1;
    step();
    bus.push = 1'b0;
    n_total++;
    if ({bus.count, bus.valid_out, bus.data_out, bus.overflow_err}
        !== {4'd8, 1'b1, 6'h21, 1'b0})
      $display("FAIL full_pp got c=%0d v=%b d=%h o=%b want 8/1/21/0",
        bus.count, bus.valid_out, bus.data_out, bus.overflow_err);
    else n_pass++;
    for (int i = 1; i < 8; i++) begin
      step();
      n_total++;
      if (bus.data_out !== 6'h21 + 6'(i))
        $display("FAIL full_pp_drain_%0d got %h want %h", i,
          bus.data_out, 6'h21 + 6'(i));
      else n_pass++;
    end
    step();
    bus.pop = 1'b0;
    n_total++;
    if ({bus.valid_out, bus.data_out, bus.count} !== {1'b1, 6'h2A, 4'd0})
      $display("FAIL full_pp_last got %b/%h c=%0d want 1/2a c=0",
        bus.valid_out, bus.data_out, bus.count);
    else n_pass++;
    // 20 alternating cycles walk both pointers past the wrap point
    for (int k = 0; k < 10; k++) begin
      d = 6'h30 + 6'(k);
      bus.push = 1'b1;
      bus.data_in = d;
      step();
      bus.push = 1'b0;
      bus.pop = 1'b1;
      step();
      bus.pop = 1'b0;
      n_total++;
      if ({bus.valid_out, bus.data_out, bus.count} !== {1'b1, d, 4'd0})
        $display("FAIL wrap_%0d got %b/%h c=%0d want 1/%h c=0", k,
          bus.valid_out, bus.data_out, bus.count, d);
      else n_pass++;
    end
  endtask

  task automatic test_underflow();
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    n_total++;
    if ({bus.underflow_err, bus.valid_out, bus.count}
        !== {1'b1, 1'b0, 4'd0})
      $display("FAIL udf got u=%b v=%b c=%0d want 1/0/0",
        bus.underflow_err, bus.valid_out, bus.count);
    else n_pass++;
    bus.push = 1'b1;
    bus.pop = 1'b1;
    bus.data_in = 6'h05;
    step();
    bus.push = 1'b0;
    bus.pop = 1'b0;
    n_total++;
    if ({bus.count, bus.valid_out, bus.empty} !== {4'd1, 1'b0, 1'b0})
      $display("FAIL nobypass got c=%0d v=%b e=%b want 1/0/0",
        bus.count, bus.valid_out, bus.empty);
    else n_pass++;
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    n_total++;
    if ({bus.valid_out, bus.data_out} !== {1'b1, 6'h05})
      $display("FAIL nobypass_rd got %b/%h want 1/05",
        bus.valid_out, bus.data_out);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus.push = 1'b1;
      bus.data_in = 6'h08 + 6'(i);
      step();
    end
    n_total++;
    if ({bus.count, bus.underflow_err} !== {4'd5, 1'b1})
      $display("FAIL mid_pre got c=%0d u=%b want 5/1",
        bus.count, bus.underflow_err);
    else n_pass++;
    bus.data_in = 6'h3C;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.push = 1'b0;
    n_total++;
    if ({bus.count, bus.empty, bus.almost_empty, bus.valid_out,
         bus.overflow_err, bus.underflow_err}
        !== {4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL mid_rst got c=%0d e=%b ae=%b v=%b o=%b u=%b",
        bus.count, bus.empty, bus.almost_empty, bus.valid_out,
        bus.overflow_err, bus.underflow_err);
    else n_pass++;
    bus.pop = 1'b1;
    step();
    bus.pop = 1'b0;
    n_total++;
    if ({bus.valid_out, bus.underflow_err, bus.count}
        !== {1'b0, 1'b1, 4'd0})
      $display("FAIL mid_discard got v=%b u=%b c=%0d want 0/1/0",
        bus.valid_out, bus.underflow_err, bus.count);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    test_reset();
    test_fill();
    test_overflow();
    test_pause();
    test_back_to_back();
    test_underflow();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
